// File: rtl/gin_pkg.sv
// Shared definitions for the GIN injection source: default widths, FSM
// state encoding and the packed operand layout carried through the queue.
package gin_pkg;

  localparam int ID_LEN_DEF    = 4;
  localparam int VALUE_LEN_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_PROG  = 2'd2;

  typedef struct packed {
    logic [ID_LEN_DEF-1:0]    row_tag;
    logic [ID_LEN_DEF-1:0]    col_tag;
    logic [VALUE_LEN_DEF-1:0] value;
  } gin_entry_t;

endpackage

// File: rtl/gin_src_fifo.sv
// Synchronous FIFO for the GIN injection queue; the head entry is visible
// combinationally so it can sit on the bus until popped.
module gin_src_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push is refused while full even if a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i  & ~empty_o;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide
  // what is valid, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gin_multicast_source.sv
// GIN injection end: queues tagged operands onto the enable/ready bus and
// programs the multicast controllers' ID scan chain (tail-first).
module gin_multicast_source
  import gin_pkg::*;
#(
  parameter int ID_LEN     = ID_LEN_DEF,
  parameter int VALUE_LEN  = VALUE_LEN_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CHAIN_LEN  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_LEN-1:0]    in_row_tag,
  input  logic [ID_LEN-1:0]    in_col_tag,
  input  logic [VALUE_LEN-1:0] in_value,
  output logic                 gin_enable,
  input  logic                 gin_ready,
  output logic [ID_LEN-1:0]    gin_row_tag,
  output logic [ID_LEN-1:0]    gin_col_tag,
  output logic [VALUE_LEN-1:0] gin_value,
  input  logic                 cfg_start,
  input  logic                 cfg_id_valid,
  input  logic [ID_LEN-1:0]    cfg_id,
  output logic                 cfg_id_ready,
  output logic                 cfg_busy,
  output logic                 set_id,
  output logic [ID_LEN-1:0]    id_out
);

  localparam int EW  = 2*ID_LEN + VALUE_LEN;
  localparam int CW  = $clog2(CHAIN_LEN+1);
  localparam int QCW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              set_id_q;
  logic [ID_LEN-1:0] id_out_q;

  logic          push, pop, full, empty, empty_next, id_accept;
  logic [EW-1:0] head;
  logic [QCW-1:0] count;

  gin_src_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_row_tag, in_col_tag, in_value}),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign in_ready   = (state_q == ST_IDLE) & ~full;
  assign push       = in_valid & in_ready;
  assign gin_enable = ~empty & (state_q != ST_PROG);
  assign pop        = gin_enable & gin_ready;
  assign {gin_row_tag, gin_col_tag, gin_value} = gin_enable ? head : '0;

  // Queue is empty after this edge: already empty, or the last entry leaves.
  assign empty_next = ((count == '0) | ((count == QCW'(1)) & pop)) & ~push;

  assign cfg_id_ready = (state_q == ST_PROG);
  assign id_accept    = cfg_id_valid & cfg_id_ready;
  assign cfg_busy     = (state_q != ST_IDLE) | set_id_q;
  assign set_id       = set_id_q;
  assign id_out       = id_out_q;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (cfg_start) state_d = empty_next ? ST_PROG : ST_DRAIN;
      ST_DRAIN: if (empty_next) state_d = ST_PROG;
      ST_PROG: begin
        if (id_accept) begin
          if (cnt_q == CW'(CHAIN_LEN-1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      set_id_q <= 1'b0;
      id_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      set_id_q <= id_accept;
      if (id_accept) id_out_q <= cfg_id;
    end
  end

endmodule

// File: tb/tb_gin_multicast_source.sv
// Directed scenarios plus randomized streaming against a queue-based model
// of the GIN injection source.
module tb_gin_multicast_source;
  import gin_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_row_tag = '0, in_col_tag = '0;
  logic [31:0] in_value = '0;
  logic        gin_enable;
  logic        gin_ready = 1'b0;
  logic [3:0]  gin_row_tag, gin_col_tag;
  logic [31:0] gin_value;
  logic        cfg_start = 1'b0, cfg_id_valid = 1'b0;
  logic [3:0]  cfg_id = '0;
  logic        cfg_id_ready, cfg_busy, set_id;
  logic [3:0]  id_out;

  int n_cmp = 0;
  int n_mis = 0;

  gin_multicast_source dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row_tag(in_row_tag), .in_col_tag(in_col_tag), .in_value(in_value),
    .gin_enable(gin_enable), .gin_ready(gin_ready),
    .gin_row_tag(gin_row_tag), .gin_col_tag(gin_col_tag), .gin_value(gin_value),
    .cfg_start(cfg_start), .cfg_id_valid(cfg_id_valid), .cfg_id(cfg_id),
    .cfg_id_ready(cfg_id_ready), .cfg_busy(cfg_busy),
    .set_id(set_id), .id_out(id_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  gin_entry_t model_q[$];
  gin_entry_t e;
  logic [31:0] r;
  logic        exp_ready, popped;

  initial begin
    // Reset
    tick(); tick();
    check("rst_gin_enable", 64'(gin_enable), 64'd0);
    check("rst_set_id",     64'(set_id),     64'd0);
    check("rst_id_out",     64'(id_out),     64'd0);
    check("rst_cfg_busy",   64'(cfg_busy),   64'd0);
    check("rst_in_ready",   64'(in_ready),   64'd1);
    check("rst_cfg_id_rdy", 64'(cfg_id_ready), 64'd0);
    check("rst_gin_value",  64'(gin_value),  64'd0);
    rst = 1'b1;
    tick();

    // Single entry
    gin_ready = 1'b1;
    in_valid = 1'b1; in_row_tag = 4'd3; in_col_tag = 4'd5; in_value = 32'hDEADBEEF;
    #1;
    check("single_in_ready", 64'(in_ready), 64'd1);
    check("single_pre_en",   64'(gin_enable), 64'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("single_en",    64'(gin_enable),  64'd1);
    check("single_row",   64'(gin_row_tag), 64'd3);
    check("single_col",   64'(gin_col_tag), 64'd5);
    check("single_value", 64'(gin_value),   64'hDEADBEEF);
    tick();
    check("single_en_off",    64'(gin_enable), 64'd0);
    check("single_value_off", 64'(gin_value),  64'd0);

    // Backpressure: five offers into a four-deep queue
    gin_ready = 1'b0;
    in_row_tag = 4'd1; in_col_tag = 4'd2;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_value = 32'(i);
      #1;
      check("bp_in_ready", 64'(in_ready), (i <= 4) ? 64'd1 : 64'd0);
      tick();
    end
    gin_ready = 1'b1;
    #1;
    check("bp_full_pop_no_push", 64'(in_ready), 64'd0);
    check("bp_value", 64'(gin_value), 64'd1);
    tick();
    check("bp_space_freed", 64'(in_ready), 64'd1);
    check("bp_value", 64'(gin_value), 64'd2);
    tick();
    in_valid = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      #1;
      check("bp_en", 64'(gin_enable), 64'd1);
      check("bp_value", 64'(gin_value), 64'(k));
      tick();
    end
    check("bp_empty", 64'(gin_enable), 64'd0);

    // Programming 12 IDs
    gin_ready = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("prog_id_ready", 64'(cfg_id_ready), 64'd1);
    check("prog_busy",     64'(cfg_busy),     64'd1);
    check("prog_in_ready", 64'(in_ready),     64'd0);
    check("prog_set_id0",  64'(set_id),       64'd0);
    for (int i = 0; i < 12; i++) begin
      cfg_id_valid = 1'b1; cfg_id = 4'(i);
      #1;
      check("prog_ready_before", 64'(cfg_id_ready), 64'd1);
      tick();
      check("prog_set_id", 64'(set_id), 64'd1);
      check("prog_id_out", 64'(id_out), 64'(i));
    end
    cfg_id = 4'd12;
    check("prog_ready_done", 64'(cfg_id_ready), 64'd0);
    check("prog_busy_last",  64'(cfg_busy),     64'd1);
    tick();
    check("prog_no_13th",  64'(set_id),   64'd0);
    check("prog_id_hold",  64'(id_out),   64'd11);
    check("prog_busy_clr", 64'(cfg_busy), 64'd0);
    cfg_id_valid = 1'b0;

    // Drain before programming
    gin_ready = 1'b0;
    in_valid = 1'b1; in_value = 32'hA; tick();
    in_value = 32'hB; tick();
    in_valid = 1'b0;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    in_valid = 1'b1; in_value = 32'hC;
    #1;
    check("drain_busy",     64'(cfg_busy),     64'd1);
    check("drain_id_ready", 64'(cfg_id_ready), 64'd0);
    check("drain_in_ready", 64'(in_ready),     64'd0);
    check("drain_en",       64'(gin_enable),   64'd1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    in_valid = 1'b0;
    gin_ready = 1'b1;
    #1;
    check("drain_v0", 64'(gin_value), 64'hA);
    tick();
    check("drain_v1", 64'(gin_value), 64'hB);
    tick();
    check("drain_prog_rdy", 64'(cfg_id_ready), 64'd1);
    check("drain_prog_en",  64'(gin_enable),   64'd0);

    // Reset in the middle of programming
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      cfg_id_valid = 1'b1; cfg_id = r[3:0];
      tick();
      check("mid_id_out", 64'(id_out), 64'(r[3:0]));
    end
    cfg_id_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("mid_rst_set_id", 64'(set_id),       64'd0);
    check("mid_rst_busy",   64'(cfg_busy),     64'd0);
    check("mid_rst_en",     64'(gin_enable),   64'd0);
    check("mid_rst_idrdy",  64'(cfg_id_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_rdy", 64'(in_ready), 64'd1);
    tick();

    // Randomized streaming against the queue model
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      r = $urandom;
      in_valid   = r[0] | r[1];
      gin_ready  = r[2] | (r[3] & r[4]);
      in_row_tag = r[11:8];
      in_col_tag = r[15:12];
      in_value   = $urandom;
      #1;
      exp_ready = (model_q.size() < 4);
      check("rnd_in_ready", 64'(in_ready),   64'(exp_ready));
      check("rnd_enable",   64'(gin_enable), 64'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        check("rnd_row",   64'(gin_row_tag), 64'(model_q[0].row_tag));
        check("rnd_col",   64'(gin_col_tag), 64'(model_q[0].col_tag));
        check("rnd_value", 64'(gin_value),   64'(model_q[0].value));
      end else begin
        check("rnd_idle_value", 64'(gin_value), 64'd0);
      end
      popped = (model_q.size() > 0) && gin_ready;
      e.row_tag = in_row_tag; e.col_tag = in_col_tag; e.value = in_value;
      tick();
      if (popped) void'(model_q.pop_front());
      if (in_valid && exp_ready) model_q.push_back(e);
    end

    // Reset with entries queued drops them
    gin_ready = 1'b0; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    check("fill_before_rst", 64'(gin_enable), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_drop_en",    64'(gin_enable), 64'd0);
    check("rst_drop_ready", 64'(in_ready),   64'd1);
    model_q.delete();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/gin_multicast_source.md
Name: gin_multicast_source

Overview:
Injection end of the global interconnect network (GIN). It queues tagged operands (row tag, column tag, value) from the buffer side and presents them on the GIN bus using the enable/ready handshake that the per-PE multicast controllers answer. It also programs the controllers' ID scan chain by driving set_id and a chain-head ID. One instance sits at the PE-array top, feeding each GIN (ifmap, filter, psum).

Parameters:
ID_LEN, 4, tag/ID width; must match the multicast controllers.
VALUE_LEN, 32, payload width.
FIFO_DEPTH, 4, injection queue depth; power of 2, >= 2.
CHAIN_LEN, 12, number of controllers on the ID scan chain.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_valid  in  1  producer has an entry
in_ready  out  1  entry accepted when in_valid & in_ready
in_row_tag  in  ID_LEN  Y-bus tag
in_col_tag  in  ID_LEN  X-bus tag
in_value  in  VALUE_LEN  payload
gin_enable  out  1  bus transfer offered
gin_ready  in  1  aggregated ready from the GIN
gin_row_tag  out  ID_LEN  row tag on bus
gin_col_tag  out  ID_LEN  column tag on bus
gin_value  out  VALUE_LEN  payload on bus
cfg_start  in  1  request ID programming (one-cycle pulse)
cfg_id_valid  in  1  programming ID available
cfg_id  in  ID_LEN  ID to shift in
cfg_id_ready  out  1  ID accepted when cfg_id_valid & cfg_id_ready
cfg_busy  out  1  programming pending or in progress
set_id  out  1  scan-chain shift strobe
id_out  out  ID_LEN  chain-head ID

Behaviour:
- Reset (rst=0 at posedge): FIFO flushed, state IDLE, prog counter 0, set_id=0, id_out=0. Outputs after reset: gin_enable=0, gin tags/value=0, cfg_busy=0, cfg_id_ready=0, in_ready=1. Reset mid-operation aborts programming and drops all queued entries.
- FSM states:
  - IDLE: streaming enabled.
  - DRAIN: cfg_start arrived with FIFO non-empty. Streaming continues, no pushes accepted.
  - PROG: accepting IDs.
- Transitions:
  - IDLE -> PROG on cfg_start when the FIFO is empty.
  - IDLE -> DRAIN on cfg_start when the FIFO is non-empty.
  - DRAIN -> PROG when the FIFO becomes empty (a pop leaving count 0).
  - PROG -> IDLE on the CHAIN_LEN-th ID accept.
  - cfg_start outside IDLE is ignored.
- in_ready = (state==IDLE) & !full. A push is never accepted while full, even with a simultaneous pop.
- gin_enable = !empty & (state!=PROG). Tags and value come from the FIFO head and are driven 0 when gin_enable=0.
- Pop on gin_enable & gin_ready. Entries stay stable on the bus until popped.
- Latency: an entry accepted at edge N is on the bus from cycle N+1. Sustained throughput is 1 entry/cycle when gin_ready=1.
- A simultaneous push and pop with the FIFO not full updates the count by 0.
- PROG:
  - cfg_id_ready=1.
  - Each accept registers set_id=1 and id_out=cfg_id for exactly the next cycle. Otherwise set_id=0 and id_out holds its value.
  - The counter (width clog2(CHAIN_LEN+1)) increments per accept.
  - IDs are shifted tail-first: the first accepted ID ends in the chain-tail controller.
- cfg_busy = (state!=IDLE) | set_id.
- Pointers wrap modulo FIFO_DEPTH. The count has one extra bit to distinguish full from empty.

Decomposition:
- Shared package gin_pkg: default ID_LEN/VALUE_LEN, FSM state encoding (IDLE/DRAIN/PROG), and a packed entry type {row_tag, col_tag, value}.
- One sub-module, gin_src_fifo: synchronous FIFO with push/pop, full/empty, and combinational head output. The FSM and scan-chain logic stay in the top.

Test Plan:
1. Reset: hold rst=0 for 2 cycles -> gin_enable=0, set_id=0, id_out=0, cfg_busy=0, in_ready=1.
2. Single entry: push row=3, col=5, value=0xDEADBEEF with gin_ready=1 -> gin_enable=1 for exactly one cycle, the cycle after accept, carrying those values; then 0.
3. Backpressure: gin_ready=0, offer 5 entries with values 1..5 -> 4 accepted, in_ready=0 on the 5th. Then gin_ready=1 -> values 1,2,3,4 on the bus on consecutive cycles, and entry 5 is accepted once space frees.
4. Programming: cfg_start, then present cfg_id=0..11 with valid held -> 12 set_id pulses, each one cycle after its accept, with id_out matching. cfg_id_ready falls after the 12th accept, a 13th ID is not accepted, and cfg_busy clears the cycle after the last set_id.
5. Drain: 2 queued entries, gin_ready=0, then cfg_start -> cfg_busy=1, cfg_id_ready=0, in_ready=0. gin_ready=1 -> both entries pop, then PROG is entered and cfg_id_ready=1.
6. Reset mid-PROG after 5 IDs -> next cycle set_id=0, cfg_busy=0, FIFO empty, and in_ready=1 once rst returns to 1.
